// File: rtl/oled_pkg.sv
// Shared OLED geometry, RGB565 colour constants and the rectangle descriptor type.
// Build option: RECT_MOTION_EN adds a signed per-slot horizontal velocity (dx).
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = 6144;

  localparam logic [15:0] COL_RED   = 16'hF800;
  localparam logic [15:0] COL_GREEN = 16'h07E0;
  localparam logic [15:0] COL_BLACK = 16'h0000;

  typedef struct packed {
    logic        en;
    logic [15:0] colour;
    logic [5:0]  y1;
    logic [6:0]  x1;
    logic [5:0]  y0;
    logic [6:0]  x0;
`ifdef RECT_MOTION_EN
    logic signed [3:0] dx;
`endif
  } rect_t;

endpackage

// File: rtl/oled_rect_hit.sv
// Combinational inclusive-bounds hit test of one rectangle against a pixel.
// Unordered bounds (x0>x1 or y0>y1) can never satisfy both compares, so they never hit.
module oled_rect_hit
  import oled_pkg::*;
(
  input  rect_t      rect,
  input  logic [6:0] x,
  input  logic [5:0] y,
  output logic       hit
);

  assign hit = rect.en
            && (rect.x0 <= x) && (x <= rect.x1)
            && (rect.y0 <= y) && (y <= rect.y1);

endmodule

// File: rtl/oled_rect_scheduler.sv
// Frame-synchronous rectangle compositor: shadow descriptors commit on frame_begin, 2-stage pixel path.
// Build option: RECT_MOTION_EN adds wr_dx and per-commit horizontal motion of unwritten slots.
module oled_rect_scheduler
  import oled_pkg::*;
#(
  parameter  int          NUM_RECT  = 4,
  parameter  logic [15:0] BG_COLOUR = 16'h07E0,
  localparam int          ID_W      = $clog2(NUM_RECT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_begin,
  input  logic [12:0]     pixel_index,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [ID_W-1:0] wr_id,
  input  logic [6:0]      wr_x0,
  input  logic [6:0]      wr_x1,
  input  logic [5:0]      wr_y0,
  input  logic [5:0]      wr_y1,
  input  logic [15:0]     wr_colour,
  input  logic            wr_en,
`ifdef RECT_MOTION_EN
  input  logic signed [3:0] wr_dx,
`endif
  output logic [15:0]     pixel_data,
  output logic            commit_pending
);

  rect_t shadow_q    [NUM_RECT];
  rect_t active_q    [NUM_RECT];
  rect_t commit_rect [NUM_RECT];
  rect_t wr_rect;

  logic wr_fire;
  logic wr_in_range;

  // Writes are refused during commits so a descriptor never lands mid-copy.
  assign wr_ready    = !reset && !frame_begin;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (int'(wr_id) < NUM_RECT);

  always_comb begin
    wr_rect        = '0;
    wr_rect.en     = wr_en;
    wr_rect.colour = wr_colour;
    wr_rect.x0     = wr_x0;
    wr_rect.x1     = wr_x1;
    wr_rect.y0     = wr_y0;
    wr_rect.y1     = wr_y1;
`ifdef RECT_MOTION_EN
    wr_rect.dx     = wr_dx;
`endif
  end

`ifdef RECT_MOTION_EN
  logic [NUM_RECT-1:0] written_q;

  // Column advance modulo the panel width; |dx| <= 8 so one correction suffices.
  function automatic logic [6:0] wrap_x(input logic [6:0] x, input logic signed [3:0] dx);
    logic signed [7:0] xs;
    logic signed [7:0] ds;
    logic signed [7:0] s;
    xs = {1'b0, x};
    ds = {{4{dx[3]}}, dx};
    s  = xs + ds;
    if (s < 8'sd0)
      s = s + 8'sd96;
    else if (s > 8'sd95)
      s = s - 8'sd96;
    return s[6:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_RECT; i++) begin
      commit_rect[i] = shadow_q[i];
      if (!written_q[i]) begin
        commit_rect[i]    = active_q[i];
        commit_rect[i].x0 = wrap_x(active_q[i].x0, active_q[i].dx);
        commit_rect[i].x1 = wrap_x(active_q[i].x1, active_q[i].dx);
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_RECT; i++)
      commit_rect[i] = shadow_q[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      commit_pending <= 1'b0;
`ifdef RECT_MOTION_EN
      written_q      <= '0;
`endif
    end else begin
      if (frame_begin) begin
        for (int i = 0; i < NUM_RECT; i++)
          active_q[i] <= commit_rect[i];
        commit_pending <= 1'b0;
`ifdef RECT_MOTION_EN
        written_q      <= '0;
`endif
      end
      // wr_fire excludes frame_begin cycles, so this never races the commit above.
      if (wr_fire && wr_in_range) begin
        for (int i = 0; i < NUM_RECT; i++) begin
          if (wr_id == ID_W'(i)) begin
            shadow_q[i] <= wr_rect;
`ifdef RECT_MOTION_EN
            written_q[i] <= 1'b1;
`endif
          end
        end
        commit_pending <= 1'b1;
      end
    end
  end

  // Stage 1: linear index to (x, y)
  logic [6:0] x_p1;
  logic [5:0] y_p1;
  logic       in_range_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_p1        <= '0;
      y_p1        <= '0;
      in_range_p1 <= 1'b0;
    end else begin
      x_p1        <= 7'(pixel_index % 13'(OLED_WIDTH));
      y_p1        <= 6'(pixel_index / 13'(OLED_WIDTH));
      in_range_p1 <= (pixel_index < 13'(OLED_PIXELS));
    end
  end

  // Stage 2: per-slot hit test against the active bank, lowest id wins
  logic [NUM_RECT-1:0] hit;
  logic [15:0]         sel_colour;

  for (genvar g = 0; g < NUM_RECT; g++) begin : g_hit
    oled_rect_hit u_hit (
      .rect (active_q[g]),
      .x    (x_p1),
      .y    (y_p1),
      .hit  (hit[g])
    );
  end

  always_comb begin
    sel_colour = BG_COLOUR;
    for (int i = NUM_RECT - 1; i >= 0; i--)
      if (hit[i])
        sel_colour = active_q[i].colour;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pixel_data <= BG_COLOUR;
    else
      pixel_data <= in_range_p1 ? sel_colour : BG_COLOUR;
  end

endmodule

// File: tb/tb_oled_rect_scheduler.sv
// Scoreboard bench for oled_rect_scheduler: pixel expectations are queued at drive time and
// compared two cycles later. Exercises the RECT_MOTION_EN path when that macro is defined.
module tb_oled_rect_scheduler;

  localparam logic [15:0] BG = 16'h07E0;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_id;
  logic [6:0]  wr_x0, wr_x1;
  logic [5:0]  wr_y0, wr_y1;
  logic [15:0] wr_colour;
  logic        wr_en;
  logic [15:0] pixel_data;
  logic        commit_pending;
`ifdef RECT_MOTION_EN
  logic signed [3:0] wr_dx;
`endif

  oled_rect_scheduler #(.NUM_RECT(4), .BG_COLOUR(BG)) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_begin    (frame_begin),
    .pixel_index    (pixel_index),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_id          (wr_id),
    .wr_x0          (wr_x0),
    .wr_x1          (wr_x1),
    .wr_y0          (wr_y0),
    .wr_y1          (wr_y1),
    .wr_colour      (wr_colour),
    .wr_en          (wr_en),
`ifdef RECT_MOTION_EN
    .wr_dx          (wr_dx),
`endif
    .pixel_data     (pixel_data),
    .commit_pending (commit_pending)
  );

  always #20 clk = ~clk;

  typedef struct {
    int x0, y0, x1, y1, colour, en, dx;
  } m_rect_t;

  m_rect_t m_sh [4];
  m_rect_t m_act[4];
  bit      m_wr [4];
  bit      m_pend;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int   due_q[$];
  int   idx_q[$];
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      chk($sformatf("pix%0d", idx_q[0]), pixel_data, exp_q[0]);
      void'(due_q.pop_front());
      void'(idx_q.pop_front());
      void'(exp_q.pop_front());
    end
  end

  function automatic logic [15:0] model_pixel(input int idx);
    int x, y;
    if (idx >= 6144) return BG;
    x = idx % 96;
    y = idx / 96;
    for (int i = 0; i < 4; i++)
      if (m_act[i].en != 0 && x >= m_act[i].x0 && x <= m_act[i].x1 &&
          y >= m_act[i].y0 && y <= m_act[i].y1)
        return 16'(m_act[i].colour);
    return BG;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = '{0, 0, 0, 0, 0, 0, 0};
      m_act[i] = '{0, 0, 0, 0, 0, 0, 0};
      m_wr[i]  = 0;
    end
    m_pend = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int idx);
    pixel_index = 13'(idx);
    due_q.push_back(cyc + 2);
    idx_q.push_back(idx);
    exp_q.push_back(model_pixel(idx));
    step();
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  task automatic write_rect(input int id, input int x0, input int y0, input int x1, input int y1,
                            input int col, input int en, input int dx);
    wr_valid  = 1'b1;
    wr_id     = 3'(id);
    wr_x0     = 7'(x0);
    wr_x1     = 7'(x1);
    wr_y0     = 6'(y0);
    wr_y1     = 6'(y1);
    wr_colour = 16'(col);
    wr_en     = 1'(en);
`ifdef RECT_MOTION_EN
    wr_dx     = 4'(dx);
`endif
    #1;
    chk("wr_ready_idle", wr_ready, 1'b1);
    step();
    if (id < 4) begin
      m_sh[id] = '{x0, y0, x1, y1, col, en, dx};
      m_wr[id] = 1;
      m_pend   = 1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 4; i++) begin
`ifdef RECT_MOTION_EN
      if (m_wr[i]) m_act[i] = m_sh[i];
      else begin
        m_act[i].x0 = ((m_act[i].x0 + m_act[i].dx) % 96 + 96) % 96;
        m_act[i].x1 = ((m_act[i].x1 + m_act[i].dx) % 96 + 96) % 96;
      end
`else
      m_act[i] = m_sh[i];
`endif
      m_wr[i] = 0;
    end
    m_pend = 0;
  endtask

  task automatic commit();
    frame_begin = 1'b1;
    #1;
    chk("wr_ready_commit", wr_ready, 1'b0);
    step();
    model_commit();
    frame_begin = 1'b0;
    #1;
    chk("pending_after_commit", commit_pending, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    frame_begin = 1'b0;
    pixel_index = '0;
    wr_valid    = 1'b0;
    wr_id       = '0;
    wr_x0       = '0;
    wr_x1       = '0;
    wr_y0       = '0;
    wr_y1       = '0;
    wr_colour   = '0;
    wr_en       = 1'b0;
`ifdef RECT_MOTION_EN
    wr_dx       = '0;
`endif
    model_clear();
    repeat (2) step();
    chk("rst_pixel", pixel_data, BG);
    chk("rst_pending", commit_pending, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("wr_ready_after_rst", wr_ready, 1'b1);

    // Empty scene: every pixel is background
    for (int i = 0; i < 6144; i++) stream(i);
    drain();

    // Slot 0 staged: invisible until the commit
    write_rect(0, 10, 10, 20, 60, 16'hF800, 1, 0);
    chk("pending_after_wr", commit_pending, 1'b1);
    stream(970); stream(5780);
    drain();
    commit();
    chk("exp970", model_pixel(970), 16'hF800);
    stream(970); stream(5780); stream(969); stream(981); stream(6200);
    drain();

    // Overlap with slot 1: slot 0 wins where both hit
    write_rect(1, 15, 10, 30, 20, 16'h001F, 1, 0);
    commit();
    stream(975); stream(985); stream(1950);
    drain();

    // Write held across a commit: refused that cycle, accepted the next
    wr_valid = 1'b1; wr_id = 3'd2; wr_x0 = 7'd40; wr_x1 = 7'd50;
    wr_y0 = 6'd30; wr_y1 = 6'd40; wr_colour = 16'hFFFF; wr_en = 1'b1;
`ifdef RECT_MOTION_EN
    wr_dx = '0;
`endif
    frame_begin = 1'b1;
    #1;
    chk("collide_ready", wr_ready, 1'b0);
    step();
    model_commit();
    frame_begin = 1'b0;
    #1;
    chk("collide_ready_next", wr_ready, 1'b1);
    step();
    m_sh[2] = '{40, 30, 50, 40, 16'hFFFF, 1, 0};
    m_wr[2] = 1; m_pend = 1;
    wr_valid = 1'b0;
    chk("collide_pending", commit_pending, 1'b1);
    stream(35 * 96 + 45);
    drain();
    chk("collide_pending_hold", commit_pending, 1'b1);
    commit();
    stream(35 * 96 + 45);
    drain();

    // Out-of-range id: accepted and discarded
    wr_valid = 1'b1; wr_id = 3'd5; wr_x0 = 7'd0; wr_x1 = 7'd95;
    wr_y0 = 6'd0; wr_y1 = 6'd63; wr_colour = 16'h1234; wr_en = 1'b1;
    #1;
    chk("oor_ready", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
    chk("oor_pending", commit_pending, 1'b0);
    commit();
    stream(0); stream(6143); stream(970);
    drain();

    // Reversed x bounds never hit
    write_rect(3, 30, 0, 20, 63, 16'hABCD, 1, 0);
    commit();
    stream(25); stream(5 * 96 + 20); stream(5 * 96 + 30); stream(63 * 96 + 25);
    drain();

    // Reset mid-frame clears everything, including a pending write
    write_rect(1, 0, 0, 95, 63, 16'h0001, 1, 0);
    pixel_index = 13'd970;
    reset = 1'b1;
    step();
    model_clear();
    chk("midrst_pixel", pixel_data, BG);
    chk("midrst_pending", commit_pending, 1'b0);
    chk("midrst_ready", wr_ready, 1'b0);
    reset = 1'b0;
    step(); step();
    chk("post_rst_pixel970", pixel_data, BG);
    commit();
    stream(970); stream(0);
    drain();

`ifdef RECT_MOTION_EN
    // Motion: slot 0 slides right by 3 per commit and wraps at column 96
    write_rect(0, 90, 0, 95, 63, 16'hF800, 1, 3);
    commit();
    stream(90); stream(95); stream(0);
    commit();
    chk("motion_x0", m_act[0].x0, 93);
    chk("motion_x1", m_act[0].x1, 2);
    stream(93); stream(95); stream(0); stream(2);
    commit();
    stream(0); stream(5); stream(6); stream(96 * 10 + 3);
    drain();
    pixel_index = 13'd0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    step();
    chk("motion_rst_pixel", pixel_data, BG);
`endif

    chk("queue_empty", due_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
